// File: rtl/shift_register_param.sv
// rtl/shift_register_param.sv - WIDTH-bit universal shift register with optional button step detect
module shift_register_param #(
    parameter int               WIDTH       = 10,
    parameter bit               EDGE_STEP   = 1'b1,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_step,
    input  logic [2:0]                 i_mode,
    input  logic                       i_val,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_led,
    output logic                       o_shift_out,
    output logic [$clog2(WIDTH+1)-1:0] o_ones,
    output logic                       o_step_ack
);

    localparam int OW = $clog2(WIDTH+1);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    function automatic logic [OW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    logic step;

    generate
        if (EDGE_STEP) begin : g_edge
            // Stages and history reset high so a button held through reset release is not a press.
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic                   hist_q, hist_d;

            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], i_step};
                hist_d = sync_q[SYNC_STAGES-1];
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    sync_q <= '1;
                    hist_q <= 1'b1;
                end else begin
                    sync_q <= sync_d;
                    hist_q <= hist_d;
                end
            end

            assign step = sync_q[SYNC_STAGES-1] & ~hist_q;
        end else begin : g_level
            assign step = i_step;
        end
    endgenerate

    logic [WIDTH-1:0] led_q, led_d;
    logic             shift_q, shift_d;
    logic [OW-1:0]    ones_q, ones_d;
    logic             ack_q, ack_d;

    always_comb begin
        led_d   = led_q;
        shift_d = shift_q;
        if (step) begin
            case (i_mode)
                MODE_SHL: begin
                    led_d   = {led_q[WIDTH-2:0], i_val};
                    shift_d = led_q[WIDTH-1];
                end
                MODE_SHR: begin
                    led_d   = {i_val, led_q[WIDTH-1:1]};
                    shift_d = led_q[0];
                end
                MODE_ROL: begin
                    led_d   = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    shift_d = led_q[WIDTH-1];
                end
                MODE_ROR: begin
                    led_d   = {led_q[0], led_q[WIDTH-1:1]};
                    shift_d = led_q[0];
                end
                MODE_LOAD: led_d = i_data;
                MODE_CLR:  led_d = '0;
                MODE_HOLD: led_d = led_q;
                default:   led_d = led_q;
            endcase
        end
        // Count from the next value so o_ones tracks o_led with no extra cycle.
        ones_d = popcount(led_d);
        ack_d  = step;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q   <= RESET_VALUE;
            shift_q <= 1'b0;
            ones_q  <= popcount(RESET_VALUE);
            ack_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            shift_q <= shift_d;
            ones_q  <= ones_d;
            ack_q   <= ack_d;
        end
    end

    assign o_led       = led_q;
    assign o_shift_out = shift_q;
    assign o_ones      = ones_q;
    assign o_step_ack  = ack_q;

endmodule
